bram_stream_reader: RTL and testbench

//   Read-side controller for a simple dual-port 1-clock BRAM (1-cycle registered read latency).
//   - Accepts a command {start address, word count}; issues sequential rden/rdAddr to the RAM.
//   - Presents returned words on a valid/ready output stream at up to 1 word/cycle.
//   - 2-entry skid buffer absorbs read latency under backpressure. Sits between feature-buffer BRAMs and compute pipes.

---
 rtl/bram_stream_reader_if.sv | 46 ++++
 rtl/bram_stream_reader.sv | 130 +++++++++++++
 tb/tb_bram_stream_reader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/bram_stream_reader_if.sv
// Bundled command, RAM read-port and output-stream signals for bram_stream_reader.
// The m_last signal exists only when BRAM_STREAM_READER_LAST_EN is defined.
interface bram_stream_reader_if #(
  parameter int unsigned C_RAM_WIDTH = 64,
  parameter int unsigned C_RAM_DEPTH = 512
);
  localparam int unsigned AW = (C_RAM_DEPTH > 1) ? $clog2(C_RAM_DEPTH) : 1;

  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [AW-1:0]          cmd_addr;
  logic [AW:0]            cmd_count;
  logic [AW-1:0]          ram_rdAddr;
  logic                   ram_rden;
  logic [C_RAM_WIDTH-1:0] ram_dataout;
  logic                   m_valid;
  logic                   m_ready;
  logic [C_RAM_WIDTH-1:0] m_data;
`ifdef BRAM_STREAM_READER_LAST_EN
  logic                   m_last;
`endif
  logic                   busy;

`ifdef BRAM_STREAM_READER_LAST_EN
  // Reader side.
  modport master (
    input  cmd_valid, cmd_addr, cmd_count, ram_dataout, m_ready,
    output cmd_ready, ram_rdAddr, ram_rden, m_valid, m_data, m_last, busy
  );
  // Command source, RAM and stream sink side.
  modport slave (
    output cmd_valid, cmd_addr, cmd_count, ram_dataout, m_ready,
    input  cmd_ready, ram_rdAddr, ram_rden, m_valid, m_data, m_last, busy
  );
`else
  modport master (
    input  cmd_valid, cmd_addr, cmd_count, ram_dataout, m_ready,
    output cmd_ready, ram_rdAddr, ram_rden, m_valid, m_data, busy
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_count, ram_dataout, m_ready,
    input  cmd_ready, ram_rdAddr, ram_rden, m_valid, m_data, busy
  );
`endif

endinterface

// File: rtl/bram_stream_reader.sv
// Sequential BRAM read controller feeding a valid/ready stream through a 2-entry skid buffer.
// Define BRAM_STREAM_READER_LAST_EN to add m_last with a per-entry last flag.
module bram_stream_reader #(
  parameter int unsigned C_RAM_WIDTH = 64,
  parameter int unsigned C_RAM_DEPTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  bram_stream_reader_if.master  bus
);

  localparam int unsigned AW = (C_RAM_DEPTH > 1) ? $clog2(C_RAM_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] LastAddr = AW'(C_RAM_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [AW-1:0]          rd_addr_q;
  logic [CW-1:0]          remaining_q, remaining_d;
  logic                   inflight_q;
  logic [C_RAM_WIDTH-1:0] buf_data_q [2];
  logic [1:0]             buf_cnt_q, buf_cnt_d;
  logic                   wr_ptr_q, rd_ptr_q;
`ifdef BRAM_STREAM_READER_LAST_EN
  logic                   inflight_last_q;
  logic                   buf_last_q [2];
`endif

  logic cmd_fire, rden, valid, pop, push, bypass;

  // The word returning from the RAM is presented directly when the buffer is
  // empty, so the first word appears the cycle after the first read.
  always_comb begin
    cmd_fire  = bus.cmd_valid && (state_q == StIdle);
    rden      = (state_q == StRead) && (remaining_q != '0) &&
                ((2'(inflight_q) + buf_cnt_q) < 2'd2);
    bypass    = (buf_cnt_q == 2'd0);
    valid     = !bypass || inflight_q;
    pop       = valid && bus.m_ready;
    push      = inflight_q && !(bypass && pop);
    buf_cnt_d = buf_cnt_q + 2'(push) - 2'(pop && !bypass);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire && (bus.cmd_count != '0)) begin
          addr_d      = bus.cmd_addr;
          remaining_d = bus.cmd_count;
          state_d     = StRead;
        end
      end
      StRead: begin
        if (rden) begin
          addr_d      = (addr_q == LastAddr) ? '0 : addr_q + AW'(1);
          remaining_d = remaining_q - CW'(1);
          if (remaining_q == CW'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        // No reads issue here, so nothing is in flight next cycle.
        if (buf_cnt_d == 2'd0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q     <= '0;
      inflight_q    <= 1'b0;
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_cnt_q     <= 2'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
    end else begin
      inflight_q <= rden;
      buf_cnt_q  <= buf_cnt_d;
      if (rden) rd_addr_q <= addr_q;
      if (push) begin
        buf_data_q[wr_ptr_q] <= bus.ram_dataout;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop && !bypass) rd_ptr_q <= ~rd_ptr_q;
    end
  end

`ifdef BRAM_STREAM_READER_LAST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_last_q <= 1'b0;
      buf_last_q[0]   <= 1'b0;
      buf_last_q[1]   <= 1'b0;
    end else begin
      inflight_last_q <= rden && (remaining_q == CW'(1));
      if (push) buf_last_q[wr_ptr_q] <= inflight_last_q;
    end
  end

  assign bus.m_last = bypass ? inflight_last_q : buf_last_q[rd_ptr_q];
`endif

  assign bus.cmd_ready  = (state_q == StIdle);
  assign bus.busy       = (state_q != StIdle);
  assign bus.ram_rden   = rden;
  // Hold the last issued address while idle rather than exposing the pointer.
  assign bus.ram_rdAddr = rden ? addr_q : rd_addr_q;
  assign bus.m_valid    = valid;
  assign bus.m_data     = !bypass ? buf_data_q[rd_ptr_q] :
                          (inflight_q ? bus.ram_dataout : '0);

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: RAM model with RAM[i]=i, depth 512 and depth 300.
module tb_bram_stream_reader;

  localparam int unsigned W = 64;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  bram_stream_reader_if #(.C_RAM_WIDTH(W), .C_RAM_DEPTH(512)) bus ();
  bram_stream_reader_if #(.C_RAM_WIDTH(W), .C_RAM_DEPTH(300)) bus2 ();

  bram_stream_reader #(.C_RAM_WIDTH(W), .C_RAM_DEPTH(512)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bram_stream_reader #(.C_RAM_WIDTH(W), .C_RAM_DEPTH(300)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read RAM models holding RAM[i] = i.
  always @(posedge clk) if (bus.ram_rden) bus.ram_dataout <= W'(bus.ram_rdAddr);
  always @(posedge clk) if (bus2.ram_rden) bus2.ram_dataout <= W'(bus2.ram_rdAddr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor for the depth-512 instance.
  logic [63:0] got_data [$];
  int          got_cyc  [$];
  bit          got_last [$];
  int          rden_cyc [$];
  int          valid_cyc[$];
  logic [63:0] got2     [$];
  int          n_busy = 0, n_notready = 0, occ_err = 0, hold_err = 0, acc_cyc = -1;
  bit          hold_v = 1'b0;
  logic [63:0] hold_d = '0;
  bit          hold_l = 1'b0;

  always @(negedge clk) begin
    bit lst;
`ifdef BRAM_STREAM_READER_LAST_EN
    lst = bus.m_last;
`else
    lst = 1'b0;
`endif
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
      if (bus.ram_rden) rden_cyc.push_back(cyc);
      if (bus.m_valid) valid_cyc.push_back(cyc);
      if (bus.busy) n_busy++;
      if (!bus.cmd_ready) n_notready++;
      if (hold_v && (!bus.m_valid || bus.m_data !== hold_d || lst !== hold_l)) hold_err++;
      hold_v = bus.m_valid && !bus.m_ready;
      hold_d = bus.m_data;
      hold_l = lst;
      if (bus.m_valid && bus.m_ready) begin
        got_data.push_back(bus.m_data);
        got_cyc.push_back(cyc);
        got_last.push_back(lst);
      end
      if (32'(dut.buf_cnt_q) + 32'(dut.inflight_q) > 2) occ_err++;
      if (bus.cmd_valid)
        assert (32'(bus.cmd_count) <= 512) else $error("FAIL cmd_count above depth");
      if (bus2.m_valid && bus2.m_ready) got2.push_back(bus2.m_data);
    end
  end

  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input int addr, input int count);
    int t = 0;
    while (!bus.cmd_ready && t < 2000) begin
      step();
      t++;
    end
    check("cmd_ready_before_cmd", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 9'(addr);
    bus.cmd_count = 10'(count);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_words(input int target, input bit patterned);
    int t = 0;
    while (got_data.size() < target && t < 5000) begin
      bus.m_ready = patterned ? pat[t % 6] : 1'b1;
      step();
      t++;
    end
    bus.m_ready = 1'b1;
    if (t >= 5000) check("stream_timeout", 64'(got_data.size()), 64'(target));
  endtask

  initial begin
    int base, rb, vb, nb, nr, mism, t;
    int exp3 [4];
    rst = 1'b1;
    bus.cmd_valid = 1'b0;  bus.cmd_addr = '0;  bus.cmd_count = '0;  bus.m_ready = 1'b1;
    bus2.cmd_valid = 1'b0; bus2.cmd_addr = '0; bus2.cmd_count = '0; bus2.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check("rst_rden", 64'(bus.ram_rden), 64'd0);
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_rdaddr", 64'(bus.ram_rdAddr), 64'd0);
    check("rst_m_data", bus.m_data, 64'd0);
`ifdef BRAM_STREAM_READER_LAST_EN
    check("rst_m_last", 64'(bus.m_last), 64'd0);
`endif
    step();
    rst = 1'b0;
    step();

    // 1: addr 10, count 4, always ready.
    base = got_data.size(); rb = rden_cyc.size(); vb = valid_cyc.size();
    send_cmd(10, 4);
    run_words(base + 4, 1'b0);
    check("t1_cmd_ready_after_last", 64'(bus.cmd_ready), 64'd1);
    check("t1_rden_latency", 64'(rden_cyc[rb] - acc_cyc), 64'd1);
    check("t1_valid_latency", 64'(valid_cyc[vb] - acc_cyc), 64'd2);
    check("t1_first_hs_latency", 64'(got_cyc[base] - acc_cyc), 64'd2);
    check("t1_back_to_back", 64'(got_cyc[base+3] - got_cyc[base]), 64'd3);
    for (int i = 0; i < 4; i++) check($sformatf("t1_word%0d", i), got_data[base+i], 64'(10 + i));
`ifdef BRAM_STREAM_READER_LAST_EN
    check("t1_last", 64'({got_last[base+3], got_last[base+2], got_last[base+1], got_last[base]}),
          64'b1000);
`endif

    // 2: addr 0, count 8, ready pattern 1,0,0,1,0,1.
    base = got_data.size();
    send_cmd(0, 8);
    run_words(base + 8, 1'b1);
    repeat (4) step();
    mism = 0;
    for (int i = 0; i < 8; i++) if (got_data[base+i] !== 64'(i)) mism++;
    check("t2_data_order", 64'(mism), 64'd0);
    check("t2_word_count", 64'(got_data.size() - base), 64'd8);

    // 3: wrap at depth 512 and at depth 300.
    base = got_data.size();
    send_cmd(510, 4);
    run_words(base + 4, 1'b0);
    exp3 = '{510, 511, 0, 1};
    for (int i = 0; i < 4; i++) check($sformatf("t3_wrap512_%0d", i), got_data[base+i], 64'(exp3[i]));
    bus2.cmd_valid = 1'b1; bus2.cmd_addr = 9'd298; bus2.cmd_count = 10'd4;
    step();
    bus2.cmd_valid = 1'b0;
    t = 0;
    while (got2.size() < 4 && t < 100) begin step(); t++; end
    check("t3_d300_count", 64'(got2.size()), 64'd4);
    exp3 = '{298, 299, 0, 1};
    for (int i = 0; i < 4; i++) check($sformatf("t3_wrap300_%0d", i), got2[i], 64'(exp3[i]));

    // 4: zero-length command.
    repeat (2) step();
    rb = rden_cyc.size(); vb = valid_cyc.size(); nb = n_busy; nr = n_notready;
    send_cmd(5, 0);
    repeat (5) step();
    check("t4_no_rden", 64'(rden_cyc.size() - rb), 64'd0);
    check("t4_no_valid", 64'(valid_cyc.size() - vb), 64'd0);
    check("t4_no_busy", 64'(n_busy - nb), 64'd0);
    check("t4_ready_held", 64'(n_notready - nr), 64'd0);

    // 5: reset mid-stream, then a fresh command.
    base = got_data.size();
    send_cmd(200, 16);
    run_words(base + 3, 1'b0);
    bus.m_ready = 1'b0;
    repeat (3) step();
    check("t5_three_words", 64'(got_data.size() - base), 64'd3);
    check("t5_third_word", got_data[base+2], 64'd202);
    rst = 1'b1;
    #1;
    check("t5_rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("t5_rst_rden", 64'(bus.ram_rden), 64'd0);
    check("t5_rst_busy", 64'(bus.busy), 64'd0);
    check("t5_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    step();
    rst = 1'b0;
    bus.m_ready = 1'b1;
    step();
    base = got_data.size();
    send_cmd(100, 2);
    run_words(base + 2, 1'b0);
    repeat (5) step();
    check("t5_post_count", 64'(got_data.size() - base), 64'd2);
    check("t5_post_w0", got_data[base], 64'd100);
    check("t5_post_w1", got_data[base+1], 64'd101);

    // 6: full-depth command, always ready.
    base = got_data.size();
    send_cmd(0, 512);
    run_words(base + 512, 1'b0);
    mism = 0;
    for (int i = 0; i < 512; i++) if (got_data[base+i] !== 64'(i)) mism++;
    check("t6_data", 64'(mism), 64'd0);
    check("t6_consecutive", 64'(got_cyc[base+511] - got_cyc[base]), 64'd511);
`ifdef BRAM_STREAM_READER_LAST_EN
    mism = 0;
    for (int i = 0; i < 511; i++) if (got_last[base+i]) mism++;
    check("t6_last_early", 64'(mism), 64'd0);
    check("t6_last_final", 64'(got_last[base+511]), 64'd1);
`endif

    check("occupancy_le_2", 64'(occ_err), 64'd0);
    check("stall_stable", 64'(hold_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
